// File: rtl/conv_sched.sv
// conv_sched: single-job scheduler for six converter units.
// Fetches one header word from the input FIFO, decodes it to a unit, starts that
// unit, waits (bounded) for its completion and then emits one output write strobe.
//
// Handshake summary:
//   FIFO side  : rden is a one-cycle strobe raised only in FETCH and only when
//                empty was 0 in the preceding IDLE cycle; datain is taken as
//                valid in the very next cycle (DECODE) and is sampled there only.
//   Unit side  : clk_en is a one-hot, one-cycle start pulse in ISSUE; the unit
//                answers with done[sel] (level or pulse) at any point during
//                WAIT. done from other units is ignored.
//   Output side: wren is a one-cycle strobe in WRITE; app/size stay stable from
//                DECODE until the next DECODE, so they can steer the output mux.
module conv_sched #(
  parameter int DATAIN  = 48,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              empty,
  input  logic [DATAIN-1:0] datain,
  output logic              rden,
  output logic [5:0]        clk_en,
  input  logic [5:0]        done,
  output logic [1:0]        app,
  output logic [2:0]        size,
  output logic              wren,
  output logic              busy,
  output logic              err,
  output logic [15:0]       job_cnt,
  output logic [15:0]       err_cnt,
  output logic [2:0]        dbg_state
);

  // FSM encoding
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_ISSUE  = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;
  localparam logic [2:0] S_WRITE  = 3'd5;

  // Last WAIT count value before the job is abandoned.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  logic [2:0]  r_state;
  logic [2:0]  w_state_nxt;
  logic        r_armed;
  logic [1:0]  r_app;
  logic [2:0]  r_size;
  logic [5:0]  r_sel_oh;
  logic [15:0] r_wait_cnt;
  logic [15:0] r_job_cnt;
  logic [15:0] r_err_cnt;

  logic [1:0]  w_hdr_app;
  logic [2:0]  w_hdr_size;
  logic        w_dec_valid;
  logic [5:0]  w_dec_sel_oh;
  logic        w_done_sel;
  logic        w_timeout;
  logic        w_err;
  logic        w_unused_payload;

  // Header fields live in the top five bits; the payload is not looked at here.
  assign w_hdr_app        = datain[DATAIN-1:DATAIN-2];
  assign w_hdr_size       = datain[DATAIN-3:DATAIN-5];
  assign w_unused_payload = ^datain[DATAIN-6:0];

  // Map {app,size} to a one-hot unit select; anything unlisted is a decode error.
  always_comb begin
    w_dec_valid  = 1'b0;
    w_dec_sel_oh = 6'b000000;
    case ({w_hdr_app, w_hdr_size})
      5'b00_001: begin w_dec_valid = 1'b1; w_dec_sel_oh = 6'b000001; end
      5'b00_010: begin w_dec_valid = 1'b1; w_dec_sel_oh = 6'b000010; end
      5'b00_011: begin w_dec_valid = 1'b1; w_dec_sel_oh = 6'b100000; end
      5'b01_001: begin w_dec_valid = 1'b1; w_dec_sel_oh = 6'b000100; end
      5'b01_010: begin w_dec_valid = 1'b1; w_dec_sel_oh = 6'b001000; end
      5'b01_011: begin w_dec_valid = 1'b1; w_dec_sel_oh = 6'b010000; end
      default:   begin w_dec_valid = 1'b0; w_dec_sel_oh = 6'b000000; end
    endcase
  end

  // Only the selected unit's completion counts; a timeout loses to a same-cycle done.
  assign w_done_sel = |(done & r_sel_oh);
  assign w_timeout  = (r_wait_cnt == TO_LAST);
  assign w_err      = ((r_state == S_DECODE) && !w_dec_valid) ||
                      ((r_state == S_WAIT) && !w_done_sel && w_timeout);

  // Next-state logic for the single-job sequence.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (r_armed && !empty) w_state_nxt = S_FETCH;
      S_FETCH:  w_state_nxt = S_DECODE;
      S_DECODE: w_state_nxt = w_dec_valid ? S_ISSUE : S_IDLE;
      S_ISSUE:  w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (w_done_sel)     w_state_nxt = S_WRITE;
        else if (w_timeout) w_state_nxt = S_IDLE;
        else                w_state_nxt = S_WAIT;
      end
      S_WRITE:  w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // State register; r_armed holds off the first fetch for one cycle after reset release.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      r_state <= S_IDLE;
      r_armed <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_armed <= 1'b1;
    end
  end

  // Capture the job header in DECODE; held until the next DECODE.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      r_app    <= 2'd0;
      r_size   <= 3'd0;
      r_sel_oh <= 6'b000000;
    end else if (r_state == S_DECODE) begin
      r_app    <= w_hdr_app;
      r_size   <= w_hdr_size;
      r_sel_oh <= w_dec_sel_oh;
    end
  end

  // WAIT-cycle counter: cleared while issuing, counts each WAIT cycle.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      r_wait_cnt <= 16'd0;
    end else if (r_state == S_ISSUE) begin
      r_wait_cnt <= 16'd0;
    end else if ((r_state == S_WAIT) && (r_wait_cnt != CNT_MAX)) begin
      r_wait_cnt <= r_wait_cnt + 16'd1;
    end
  end

  // Completed-job counter, saturating.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      r_job_cnt <= 16'd0;
    end else if ((r_state == S_WRITE) && (r_job_cnt != CNT_MAX)) begin
      r_job_cnt <= r_job_cnt + 16'd1;
    end
  end

  // Error counter (decode errors and timeouts), saturating.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      r_err_cnt <= 16'd0;
    end else if (w_err && (r_err_cnt != CNT_MAX)) begin
      r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  // Strobes are decoded straight from the state register so reset clears them at once.
  assign rden      = (r_state == S_FETCH);
  assign clk_en    = (r_state == S_ISSUE) ? r_sel_oh : 6'b000000;
  assign wren      = (r_state == S_WRITE);
  assign busy      = (r_state != S_IDLE);
  assign err       = w_err;
  assign app       = r_app;
  assign size      = r_size;
  assign job_cnt   = r_job_cnt;
  assign err_cnt   = r_err_cnt;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_conv_sched.sv
// tb_conv_sched: randomized job stream against a timeline model of the scheduler.
module tb_conv_sched;

  localparam int DW = 48;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rstn;
  logic          empty;
  logic [DW-1:0] datain;
  logic [5:0]    done;
  logic          rden;
  logic [5:0]    clk_en;
  logic [1:0]    app;
  logic [2:0]    size;
  logic          wren;
  logic          busy;
  logic          err;
  logic [15:0]   job_cnt;
  logic [15:0]   err_cnt;
  logic [2:0]    dbg_state;

  conv_sched #(.DATAIN(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rstn(rstn), .empty(empty), .datain(datain), .rden(rden),
    .clk_en(clk_en), .done(done), .app(app), .size(size), .wren(wren),
    .busy(busy), .err(err), .job_cnt(job_cnt), .err_cnt(err_cnt),
    .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  // FIFO contents and expected counters
  logic [DW-1:0] fifo_q[$];
  int exp_job = 0;
  int exp_err = 0;
  int prev_rden_cyc = -1;
  bit prev_valid = 0;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1);
  end

  // Header -> unit table (-1 = decode error).
  function automatic int ref_unit(input logic [1:0] a, input logic [2:0] s);
    int u;
    u = -1;
    if (a == 2'd0) begin
      if (s == 3'd1) u = 0;
      else if (s == 3'd2) u = 1;
      else if (s == 3'd3) u = 5;
    end else if (a == 2'd1) begin
      if (s == 3'd1) u = 2;
      else if (s == 3'd2) u = 3;
      else if (s == 3'd3) u = 4;
    end
    return u;
  endfunction

  function automatic logic [DW-1:0] make_word(input logic [1:0] a, input logic [2:0] s);
    logic [10:0] hi;
    logic [31:0] lo;
    hi = 11'($urandom);
    lo = $urandom;
    return {a, s, hi, lo};
  endfunction

  task automatic push_word(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    empty = 1'b0;
  endtask

  // Runs the job at the head of the FIFO. dly = WAIT cycles before done[unit] rises.
  task automatic run_job(input int dly, input string tag);
    logic [DW-1:0] word;
    logic [5:0]    d;
    logic [5:0]    exp_ce;
    logic          exp_wren;
    logic          exp_err_b;
    logic          exp_busy;
    int unit, wren_k, err_k, end_k;
    bit seen;
    word = fifo_q[0];
    unit = ref_unit(word[DW-1 -: 2], word[DW-3 -: 3]);
    // Timeline offsets relative to the rden cycle (k=0).
    if (unit < 0) begin
      wren_k = -1; err_k = 1; end_k = 2;
    end else if (dly <= TO - 1) begin
      wren_k = 4 + dly; err_k = -1; end_k = wren_k + 1;
    end else begin
      wren_k = -1; err_k = 3 + TO - 1; end_k = err_k + 1;
    end
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (rden === 1'b1) seen = 1;
    end
    n_vec++;
    if (!seen) begin
      n_bad++;
      $display("FAIL %s rden: saw no pulse in 30 cycles, expected one", tag);
      void'(fifo_q.pop_front());
      empty = (fifo_q.size() == 0);
      return;
    end
    if (prev_rden_cyc >= 0 && prev_valid) begin
      n_vec++;
      if (cyc - prev_rden_cyc < 5) begin
        n_bad++;
        $display("FAIL %s rden_gap: got %0d cycles, expected >= 5", tag, cyc - prev_rden_cyc);
      end
    end
    prev_rden_cyc = cyc;
    prev_valid = (unit >= 0);
    for (int k = 1; k <= end_k; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) begin
        datain = word;
        void'(fifo_q.pop_front());
        empty = (fifo_q.size() == 0);
      end
      d = 6'($urandom_range(0, 63));
      if (unit >= 0) d[unit] = (k >= 3) && ((k - 3) >= dly);
      done = d;
      @(negedge clk);
      exp_ce = 6'b000000;
      if (unit >= 0 && k == 2) exp_ce[unit] = 1'b1;
      exp_wren  = (k == wren_k);
      exp_err_b = (k == err_k);
      exp_busy  = (k < end_k);
      n_vec++;
      if (rden !== 1'b0 || clk_en !== exp_ce || wren !== exp_wren ||
          err !== exp_err_b || busy !== exp_busy) begin
        n_bad++;
        $display("FAIL %s k=%0d: got rden=%b clk_en=%b wren=%b err=%b busy=%b, expected rden=0 clk_en=%b wren=%b err=%b busy=%b",
                 tag, k, rden, clk_en, wren, err, busy, exp_ce, exp_wren, exp_err_b, exp_busy);
      end
    end
    if (unit >= 0 && dly <= TO - 1) begin
      if (exp_job < 65535) exp_job++;
    end else begin
      if (exp_err < 65535) exp_err++;
    end
    n_vec++;
    if (job_cnt !== 16'(exp_job) || err_cnt !== 16'(exp_err)) begin
      n_bad++;
      $display("FAIL %s counters: got job_cnt=%0d err_cnt=%0d, expected %0d %0d",
               tag, job_cnt, err_cnt, exp_job, exp_err);
    end
    n_vec++;
    if (app !== word[DW-1 -: 2] || size !== word[DW-3 -: 3]) begin
      n_bad++;
      $display("FAIL %s header: got app=%0d size=%0d, expected %0d %0d",
               tag, app, size, word[DW-1 -: 2], word[DW-3 -: 3]);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b1; empty = 1'b1; datain = '0; done = '0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({rden, clk_en, wren, err, busy, app, size, job_cnt, err_cnt} !== '0) begin
      n_bad++;
      $display("FAIL reset_state: got rden=%b clk_en=%b wren=%b err=%b busy=%b app=%0d size=%0d job=%0d err_cnt=%0d, expected all 0",
               rden, clk_en, wren, err, busy, app, size, job_cnt, err_cnt);
    end
    push_word(make_word(2'd0, 3'd1));
    rstn = 1'b0;
    @(negedge clk);
    n_vec++;
    if (rden !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_first_rden: got rden=%b one cycle after release, expected 0", rden);
    end
    run_job(2, "float_fixed_u0");
  endtask

  task automatic test_fixed_to_float();
    push_word(make_word(2'd1, 3'd3));
    run_job(0, "fixed_float_u4");
  endtask

  task automatic test_decode_error();
    push_word(make_word(2'd2, 3'd1));
    run_job(0, "decode_err");
    push_word(make_word(2'd0, 3'd0));
    run_job(0, "decode_err_size0");
  endtask

  task automatic test_timeout();
    push_word(make_word(2'd0, 3'd2));
    run_job(100, "timeout");
    push_word(make_word(2'd0, 3'd2));
    run_job(1, "after_timeout");
    push_word(make_word(2'd1, 3'd1));
    run_job(TO - 1, "done_wins_tie");
  endtask

  task automatic test_back_to_back();
    push_word(make_word(2'd0, 3'd3));
    push_word(make_word(2'd1, 3'd2));
    push_word(make_word(2'd0, 3'd1));
    run_job(0, "b2b_1");
    run_job(0, "b2b_2");
    run_job(3, "b2b_3");
  endtask

  task automatic test_reset_midjob();
    bit seen;
    done = '0;
    push_word(make_word(2'd0, 3'd1));
    push_word(make_word(2'd1, 3'd2));
    run_job(0, "midjob_1");
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (rden === 1'b1) seen = 1;
    end
    @(posedge clk);
    #1;
    datain = fifo_q.pop_front();
    empty = (fifo_q.size() == 0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (!seen || busy !== 1'b1 || wren !== 1'b0) begin
      n_bad++;
      $display("FAIL midjob_wait: got seen=%0d busy=%b wren=%b, expected 1 1 0", seen, busy, wren);
    end
    #2 rstn = 1'b1;
    #1;
    n_vec++;
    if ({rden, clk_en, wren, err, busy, job_cnt, err_cnt, app, size} !== '0) begin
      n_bad++;
      $display("FAIL midjob_reset: got rden=%b clk_en=%b wren=%b err=%b busy=%b job=%0d err_cnt=%0d app=%0d size=%0d, expected all 0",
               rden, clk_en, wren, err, busy, job_cnt, err_cnt, app, size);
    end
    @(negedge clk);
    rstn = 1'b0;
    exp_job = 0; exp_err = 0; prev_rden_cyc = -1; prev_valid = 0;
    repeat (3) @(negedge clk);
    n_vec++;
    if (rden !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL midjob_no_reread: got rden=%b busy=%b, expected 0 0", rden, busy);
    end
    push_word(make_word(2'd1, 3'd1));
    run_job(2, "after_midjob_reset");
  endtask

  task automatic test_random();
    logic [1:0] a;
    logic [2:0] s;
    int pair;
    for (int it = 0; it < 40; it++) begin
      pair = $urandom_range(0, 1);
      for (int j = 0; j <= pair; j++) begin
        if ($urandom_range(0, 3) != 0) begin
          a = 2'($urandom_range(0, 1));
          s = 3'($urandom_range(1, 3));
        end else begin
          a = 2'($urandom_range(0, 3));
          s = 3'($urandom_range(0, 7));
        end
        push_word(make_word(a, s));
      end
      for (int j = 0; j <= pair; j++) begin
        run_job($urandom_range(0, TO + 2), "random");
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_fixed_to_float();
    test_decode_error();
    test_timeout();
    test_back_to_back();
    test_reset_midjob();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/conv_sched.md
CONV_SCHED -- requirements
Module: conv_sched

Interface
REQ-001 Parameter DATAIN, default 48: width of the input FIFO word. The header occupies the top 5 bits.
REQ-002 Parameter TIMEOUT, default 64: maximum cycles to wait for a unit done, range 2..65535.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rstn  input  1  reset, asynchronous, active-high (1 = reset asserted).
REQ-005 empty  input  1  input FIFO empty flag.
REQ-006 datain  input  DATAIN  FIFO read data, valid the cycle after rden=1.
REQ-007 rden  output  1  FIFO read strobe, one-cycle pulse.
REQ-008 clk_en  output  6  one-hot start pulse to converter units 0..5.
REQ-009 done  input  6  per-unit completion flags, level or pulse.
REQ-010 app  output  2  registered app field of the current job (drives the output mux).
REQ-011 size  output  3  registered size field of the current job.
REQ-012 wren  output  1  output write strobe, one-cycle pulse.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 err  output  1  one-cycle pulse on a decode error or timeout.
REQ-015 job_cnt  output  16  count of completed jobs; saturates at 16'hFFFF.
REQ-016 err_cnt  output  16  count of errors; saturates at 16'hFFFF.

Function
REQ-017 The header fields SHALL be app = datain[DATAIN-1:DATAIN-2] and size = datain[DATAIN-3:DATAIN-5].
REQ-018 Unit mapping SHALL be as follows. app=0 (float-to-fixed): size 1->unit0, 2->unit1, 3->unit5. app=1 (fixed-to-float): size 1->unit2, 2->unit3, 3->unit4. Any other app/size combination is a decode error.
REQ-019 The FSM states SHALL be IDLE, FETCH, DECODE, ISSUE, WAIT, WRITE.
REQ-020 In IDLE with empty=0, the FSM SHALL go to FETCH; rden=1 for exactly that FETCH cycle.
REQ-021 FETCH SHALL go to DECODE unconditionally. In DECODE, datain is sampled and app/size/sel are registered.
REQ-022 DECODE with a valid mapping SHALL go to ISSUE.
REQ-023 DECODE with an invalid mapping SHALL pulse err, increment err_cnt, issue no clk_en, and go to IDLE.
REQ-024 In ISSUE, clk_en[sel] SHALL be 1 for exactly one cycle; all other clk_en bits are 0. The counter is cleared and the FSM goes to WAIT.
REQ-025 In WAIT, only done[sel] SHALL be honoured. done on other units is ignored.
REQ-026 In WAIT with done[sel]=1, the FSM SHALL go to WRITE.
REQ-027 If the counter reaches TIMEOUT-1 without done[sel], the FSM SHALL pulse err, increment err_cnt, and go to IDLE with no wren.
REQ-028 If done[sel] and the timeout arrive in the same cycle, done SHALL win: no error.
REQ-029 WRITE SHALL assert wren for one cycle, increment job_cnt, and return to IDLE.
REQ-030 Minimum job latency SHALL be 5 cycles from the rden pulse to the wren pulse (FETCH, DECODE, ISSUE, WAIT with done already high, WRITE).
REQ-031 At most one job SHALL be in flight. rden is never asserted outside FETCH.
REQ-032 empty rising during DECODE, ISSUE, WAIT or WRITE SHALL NOT affect the current job.
REQ-033 app and size SHALL hold their values from DECODE until the next DECODE.
REQ-034 A counter increment that coincides with saturation SHALL hold at 16'hFFFF.

Reset
REQ-035 While rstn=1: state=IDLE, rden=0, clk_en=0, wren=0, err=0, busy=0, app=0, size=0, job_cnt=0, err_cnt=0, timeout counter=0.
REQ-036 Reset asserted mid-job SHALL abort the job immediately with no wren. After release, the FSM restarts from IDLE; a lost FIFO word is not re-read.
REQ-037 The first rden SHALL occur no earlier than the second rising edge after rstn deasserts with empty=0.

Verification
REQ-038 Header app=0, size=1, done[0] high 3 cycles after ISSUE -> clk_en=6'b000001 one cycle, wren one cycle, job_cnt=1, err=0.
REQ-039 Header app=1, size=3, done[4] already high -> clk_en=6'b010000, wren exactly 4 cycles after rden, app=1, size=3.
REQ-040 Header app=2, size=1 -> no clk_en, err pulse in the DECODE cycle, err_cnt=1, FSM returns to IDLE.
REQ-041 TIMEOUT=8, app=0, size=2, done held 0 (done[0] toggling) -> err after 8 WAIT cycles, no wren, err_cnt=1; the next valid job completes normally.
REQ-042 Three back-to-back FIFO words with empty=0 -> three rden pulses each separated by at least 5 cycles, job_cnt=3. Reset asserted during WAIT of job 2 -> outputs zero, job_cnt=0.
